// File: rtl/input_debouncer.sv
// Multi-channel input conditioner: 2-flop synchroniser, tick-based debounce, edge pulses.
// Optional auto-repeat pulses are built only when INPUT_DEBOUNCER_REPEAT_EN is defined.
module input_debouncer #(
  parameter int                     CHANNELS     = 21,
  parameter int                     TICK_DIV     = 50000,
  parameter int                     STABLE_TICKS = 20,
  parameter logic [CHANNELS-1:0]    INVERT_MASK  = '0,
  parameter int                     REPEAT_DELAY = 500,
  parameter int                     REPEAT_RATE  = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rpt,
  output logic                changed,
  output logic                tick
);

  // No handshake: every output is valid on every cycle; rise/fall/rpt/changed
  // are registered single-cycle strobes.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync;
  logic [PW-1:0]       pre;
  logic [CW-1:0]       cnt   [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre <= '0;
    end else if (pre == PW'(TICK_DIV - 1)) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick = (pre == PW'(TICK_DIV - 1));

  // A channel accepts the synchronised value only after STABLE_TICKS
  // consecutive ticks in which it disagreed with the current level.
  always_comb begin
    level_d = level;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt[i];
      if (tick) begin
        if (sync[i] != level[i]) begin
          if (cnt[i] == CW'(STABLE_TICKS - 1)) begin
            level_d[i] = sync[i];
            cnt_d[i]   = '0;
            rise_d[i]  = sync[i];
            fall_d[i]  = ~sync[i];
          end else begin
            cnt_d[i] = cnt[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= '0;
      sync    <= '0;
      level   <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      sync1   <= raw_in ^ INVERT_MASK;
      sync    <= sync1;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
      changed <= |(rise_d | fall_d);
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_d[i];
    end
  end

`ifdef INPUT_DEBOUNCER_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0]       rcnt    [CHANNELS];
  logic [RW-1:0]       rcnt_d  [CHANNELS];
  logic [CHANNELS-1:0] started;
  logic [CHANNELS-1:0] started_d;
  logic [CHANNELS-1:0] rpt_d;

  // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE; a fall wins over a repeat.
  always_comb begin
    rpt_d     = '0;
    started_d = started;
    for (int i = 0; i < CHANNELS; i++) begin
      rcnt_d[i] = rcnt[i];
      if (!level[i] || fall_d[i]) begin
        rcnt_d[i]    = '0;
        started_d[i] = 1'b0;
      end else if (tick) begin
        if (( started[i] && rcnt[i] == RW'(REPEAT_RATE - 1)) ||
            (!started[i] && rcnt[i] == RW'(REPEAT_DELAY - 1))) begin
          rpt_d[i]     = 1'b1;
          rcnt_d[i]    = '0;
          started_d[i] = 1'b1;
        end else begin
          rcnt_d[i] = rcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt     <= '0;
      started <= '0;
      for (int i = 0; i < CHANNELS; i++) rcnt[i] <= '0;
    end else begin
      rpt     <= rpt_d;
      started <= started_d;
      for (int i = 0; i < CHANNELS; i++) rcnt[i] <= rcnt_d[i];
    end
  end
`else
  assign rpt = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with a tick-window reference model checked every cycle.
module tb_input_debouncer;
  localparam int CH = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam logic [CH-1:0] MASK = 4'b1000;
  localparam int RD = 5;
  localparam int RR = 2;

  logic          clk;
  logic          reset;
  logic [CH-1:0] raw_in;
  logic [CH-1:0] level, rise, fall, rpt;
  logic          changed, tick;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  input_debouncer #(
    .CHANNELS(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .INVERT_MASK(MASK),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .level(level), .rise(rise),
    .fall(fall), .rpt(rpt), .changed(changed), .tick(tick)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // reference model: level flips once the last ST tick samples all disagree with it
  logic [CH-1:0] m_s1 = '0, m_s2 = '0;
  logic [CH-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_rpt = '0;
  logic          m_changed = 1'b0;
  logic [ST-1:0] m_win [CH];
  int            m_nrise [CH];
  int            m_cyc = 0;
  int            m_nt = 0;

  task automatic model_step();
    logic [CH-1:0] sync_now;
    bit tk;
    sync_now = m_s2;
    m_rise = '0;
    m_fall = '0;
    m_rpt  = '0;
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_cyc = 0; m_nt = 0; m_level = '0; m_changed = 1'b0;
      for (int ch = 0; ch < CH; ch++) begin
        m_win[ch] = '0;
        m_nrise[ch] = 0;
      end
    end else begin
      tk = ((m_cyc % TD) == TD - 1);
      if (tk) begin
        if (m_nt < ST) m_nt++;
        for (int ch = 0; ch < CH; ch++) begin
          m_win[ch] = {m_win[ch][ST-2:0], sync_now[ch]};
          if (m_nt >= ST && m_win[ch] == {ST{~m_level[ch]}}) begin
            m_level[ch] = ~m_level[ch];
            if (m_level[ch]) begin
              m_rise[ch] = 1'b1;
              m_nrise[ch] = 0;
            end else begin
              m_fall[ch] = 1'b1;
            end
          end else if (m_level[ch]) begin
            m_nrise[ch]++;
`ifdef INPUT_DEBOUNCER_REPEAT_EN
            if (m_nrise[ch] >= RD && ((m_nrise[ch] - RD) % RR) == 0) m_rpt[ch] = 1'b1;
`endif
          end
        end
      end
      m_changed = |(m_rise | m_fall);
      m_s2 = m_s1;
      m_s1 = raw_in ^ MASK;
      m_cyc++;
    end
  endtask

  initial begin
    for (int ch = 0; ch < CH; ch++) begin
      m_win[ch] = '0;
      m_nrise[ch] = 0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // scoreboard: one expected vector per cycle
  logic [17:0] exp_q[$];

  initial begin
    logic [17:0] act, exp_v;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        exp_q.push_back({m_level, m_rise, m_fall, m_rpt, m_changed, ((m_cyc % TD) == TD - 1)});
        exp_v = exp_q.pop_front();
        act = {level, rise, fall, rpt, changed, tick};
        n_cmp++;
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_model t=%0t got %h expected %h (lvl,rise,fall,rpt,chg,tick)", $time, act, exp_v);
        end
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic wait_edge(input logic [CH-1:0] mask, input bit want_fall, output int n);
    bit found;
    found = 0;
    n = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (((want_fall ? fall : rise) & mask) != '0) found = 1;
    end
    if (!found) begin
      n = -1;
      n_cmp++;
      n_fail++;
      $display("FAIL wait_edge timeout: got no edge expected mask %b", mask);
    end
  endtask

  initial begin
    int n, ticks, rcount;
    int rtimes[3];
    bit bad;
    raw_in = '0;
    reset  = 1'b0;

    // reset and the inverted channel's power-up rise
    @(negedge clk);
    cmp_en = 1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {14'd0, level, rise, fall, rpt, changed, tick}, 32'd0);
    reset = 1'b1;
    wait_edge(4'b1000, 0, n);
    check("reset_rise_cycle", n, 12);
    check("reset_level", level, 4'b1000);
    check("reset_rise", rise, 4'b1000);
    check("reset_changed", changed, 1);
    @(negedge clk);
    check("reset_rise_single", rise, 4'b0000);

    // clean edge
    raw_in[0] = 1'b1;
    wait_edge(4'b0001, 0, n);
    check("clean_latency_window", (n >= 11 && n <= 14), 1);
    check("clean_rise", rise, 4'b0001);
    check("clean_level", level, 4'b1001);
    @(negedge clk);
    check("clean_rise_single", rise, 4'b0000);

    // short glitch
    raw_in[1] = 1'b1;
    repeat (5) @(negedge clk);
    raw_in[1] = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rise[1] || fall[1] || level[1]) bad = 1;
    end
    check("glitch_ignored", bad, 0);

    // simultaneous rise on two channels
    raw_in[0] = 1'b0;
    raw_in[3] = 1'b1;
    repeat (30) @(negedge clk);
    check("pre_simul_level", level, 4'b0000);
    raw_in[2] = 1'b1;
    raw_in[3] = 1'b0;
    wait_edge(4'b1100, 0, n);
    check("simul_rise", rise, 4'b1100);
    check("simul_level", level, 4'b1100);
    check("simul_changed", changed, 1);

    // reset in the middle of a debounce count
    raw_in[0] = 1'b1;
    ticks = 0;
    bad = 0;
    for (int i = 0; i < 50 && ticks < 2; i++) begin
      @(negedge clk);
      if (tick) ticks++;
      if (rise[0]) bad = 1;
    end
    check("midcount_no_pulse", bad, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midcount_reset_level", level, 4'b0000);
    reset = 1'b1;
    wait_edge(4'b0001, 0, n);
    check("midcount_rise_cycle", n, 12);
    check("midcount_rise", rise, 4'b1101);

    // auto-repeat while held
    rcount = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rpt[0]) begin
        if (rcount < 3) rtimes[rcount] = i;
        rcount++;
      end
    end
`ifdef INPUT_DEBOUNCER_REPEAT_EN
    check("rpt_count", rcount, 3);
    check("rpt_first", rtimes[0], 20);
    check("rpt_second", rtimes[1], 28);
    check("rpt_third", rtimes[2], 36);
`else
    check("rpt_absent", rcount, 0);
`endif
    raw_in[0] = 1'b0;
    wait_edge(4'b0001, 1, n);
    check("release_fall", fall, 4'b0001);
    rcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (rpt[0]) rcount++;
    end
    check("rpt_stops_after_fall", rcount, 0);

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
